// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: serially loaded duty shadows feeding CH gapless PWM outputs,
// one period per frame, one-shot or continuous, left- or right-aligned.
module pwm_multi_ch #(
    parameter int CH     = 8,
    parameter int DWIDTH = 8
) (
    input  logic              clkforcounter,
    input  logic              rst,
    input  logic              start,
    input  logic              data_valid,
    input  logic [DWIDTH-1:0] data,
    output logic              data_ready,
    input  logic              mode,
    input  logic              align,
    input  logic              stop,
    output logic [0:CH-1]     out,
    output logic              hsync,
    output logic              load_done,
    output logic              done,
    output logic              busy
);
    localparam int IW = $clog2(CH);
    localparam logic [DWIDTH-1:0] PMAX = '1;
    localparam logic [DWIDTH-1:0] LAST = PMAX - DWIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_d;

    logic [DWIDTH-1:0] shadow [CH];
    logic [DWIDTH-1:0] active [CH];
    logic [DWIDTH-1:0] cnt;
    logic [IW-1:0]     idx, cap_idx;
    logic loading, shadow_full, ld_pend, mode_r, align_r;
    logic start_ok, cap, cap_last, period_end, frame_go, finish;

    always_comb begin
        start_ok   = start && !shadow_full;
        cap        = data_valid && (start_ok || loading);
        cap_idx    = start_ok ? '0 : idx;
        cap_last   = cap && cap_idx == IW'(CH - 1);
        period_end = state == RUN && cnt == LAST;
        frame_go   = state == IDLE ? shadow_full : !stop && period_end && mode_r;
        finish     = state == RUN && (stop || (period_end && !mode_r));
        state_d    = frame_go ? RUN : finish ? IDLE : state;
    end

    always_ff @(posedge clkforcounter) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clkforcounter) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            out         <= '0;
            cnt         <= '0;
            idx         <= '0;
            loading     <= 1'b0;
            shadow_full <= 1'b0;
            ld_pend     <= 1'b0;
            load_done   <= 1'b0;
            hsync       <= 1'b0;
            done        <= 1'b0;
            mode_r      <= 1'b0;
            align_r     <= 1'b0;
        end else begin
            hsync       <= frame_go;
            done        <= finish;
            // load_done is delayed so it lines up with the hsync of a frame started from IDLE
            ld_pend     <= cap_last;
            load_done   <= ld_pend;
            if (cap) shadow[cap_idx] <= data;
            idx         <= cap ? cap_idx + IW'(1) : start_ok ? '0 : idx;
            loading     <= cap_last ? 1'b0 : start_ok ? 1'b1 : loading;
            shadow_full <= cap_last ? 1'b1 : frame_go ? 1'b0 : shadow_full;
            if (frame_go && shadow_full)
                for (int k = 0; k < CH; k++) active[k] <= shadow[k];
            if (frame_go) begin
                mode_r  <= mode;
                align_r <= align;
            end
            cnt <= frame_go ? '0 : state == RUN ? cnt + DWIDTH'(1) : cnt;
            for (int k = 0; k < CH; k++)
                out[k] <= state == RUN && !stop && (align_r ? cnt >= PMAX - active[k] : cnt < active[k]);
        end
    end

    assign data_ready = loading;
    assign busy       = state == RUN;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed scenario bench for pwm_multi_ch (CH=8, DWIDTH=8, period 255).
module tb_pwm_multi_ch;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, data_valid = 1'b0;
    logic mode = 1'b0, align = 1'b0, stop = 1'b0;
    logic [7:0] data = '0;
    logic data_ready, hsync, load_done, done, busy;
    logic [0:7] out;

    int total = 0, passed = 0;
    logic [7:0] ld_vals [8];
    int hi [8];
    int done_c, hs_c, first0, last0, ldn;
    logic [0:7] out_c1;
    logic dr_any;

    always #5 clk = ~clk;

    pwm_multi_ch #(.CH(8), .DWIDTH(8)) dut (
        .clkforcounter(clk), .rst(rst), .start(start), .data_valid(data_valid),
        .data(data), .data_ready(data_ready), .mode(mode), .align(align),
        .stop(stop), .out(out), .hsync(hsync), .load_done(load_done),
        .done(done), .busy(busy)
    );

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 8; i++) ld_vals[i] = v;
    endtask

    // returns at the negedge of the cycle just after the last beat was captured
    task automatic load_vals();
        @(negedge clk);
        start = 1'b1; data_valid = 1'b1; data = ld_vals[0];
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0; data = ld_vals[i];
        end
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // entered at the negedge of an hsync cycle t0; samples cycles t0+1 .. t0+255
    task automatic measure(input int load_at, input int junk_at);
        for (int k = 0; k < 8; k++) hi[k] = 0;
        done_c = -1; hs_c = -1; first0 = -1; last0 = -1; ldn = 0; dr_any = 1'b0;
        for (int c = 1; c <= 255; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) if (out[k]) hi[k]++;
            if (out[0]) begin
                if (first0 < 0) first0 = c;
                last0 = c;
            end
            if (c == 1) out_c1 = out;
            if (done) done_c = c;
            if (hsync && hs_c < 0) hs_c = c;
            if (load_done) ldn++;
            if (junk_at > 0 && c >= junk_at && c <= junk_at + 2) dr_any |= data_ready;
            if (load_at > 0 && c >= load_at && c <= load_at + 8) begin
                start = (c == load_at);
                data_valid = (c < load_at + 8);
                if (c < load_at + 8) data = ld_vals[c - load_at];
            end
            if (junk_at > 0 && c >= junk_at && c <= junk_at + 2) begin
                start = (c == junk_at);
                data_valid = (c < junk_at + 2);
                data = 8'hFF;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (out !== 8'h00) $display("FAIL reset_out: got %h want 00", out); else passed++;
        total++; if ({hsync, load_done, done, busy, data_ready} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {hsync, load_done, done, busy, data_ready}); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_oneshot_left();
        mode = 1'b0; align = 1'b0;
        ld_vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'h10, 8'h20};
        load_vals();
        @(negedge clk);
        total++; if ({hsync, load_done, busy} !== 3'b111)
            $display("FAIL left_start: hsync/load_done/busy got %b want 111", {hsync, load_done, busy}); else passed++;
        measure(0, 0);
        total++; if (out_c1 !== 8'b0111_1111) $display("FAIL left_first_cycle: got %b want 01111111", out_c1); else passed++;
        for (int k = 0; k < 8; k++) begin
            total++; if (hi[k] !== int'(ld_vals[k]))
                $display("FAIL left_high_ch%0d: got %0d want %0d", k, hi[k], ld_vals[k]); else passed++;
        end
        total++; if (done_c !== 255) $display("FAIL left_done_cycle: got %0d want 255", done_c); else passed++;
        @(negedge clk);
        total++; if ({out, busy, done} !== 10'b0) $display("FAIL left_after: out/busy/done got %b want 0", {out, busy, done}); else passed++;
    endtask

    task automatic test_right();
        mode = 1'b0; align = 1'b1;
        set_all(8'h00); ld_vals[0] = 8'h03;
        load_vals();
        @(negedge clk);
        total++; if (hsync !== 1'b1) $display("FAIL right_hsync: got %b want 1", hsync); else passed++;
        measure(0, 0);
        total++; if (first0 !== 253 || last0 !== 255 || hi[0] !== 3)
            $display("FAIL right_window: got first %0d last %0d count %0d want 253 255 3", first0, last0, hi[0]); else passed++;
        total++; if (hi[1] !== 0) $display("FAIL right_zero_duty: got %0d want 0", hi[1]); else passed++;
        align = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_restart();
        int ldc = 0;
        mode = 1'b0; align = 1'b0;
        total++; if (data_ready !== 1'b0) $display("FAIL restart_ready_idle: got %b want 0", data_ready); else passed++;
        start = 1'b1; data_valid = 1'b1; data = 8'h11;
        @(negedge clk);
        total++; if (data_ready !== 1'b1) $display("FAIL restart_ready_loading: got %b want 1", data_ready); else passed++;
        start = 1'b0; data = 8'h22;
        @(negedge clk); ldc += int'(load_done);
        start = 1'b1; data = 8'h33;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); ldc += int'(load_done);
            start = 1'b0; data = 8'h44 + 8'(8'h11 * i);
        end
        @(negedge clk); ldc += int'(load_done);
        data_valid = 1'b0;
        @(negedge clk); ldc += int'(load_done);
        total++; if (hsync !== 1'b1) $display("FAIL restart_hsync: got %b want 1", hsync); else passed++;
        measure(0, 0);
        ldc += ldn;
        total++; if (ldc !== 1) $display("FAIL restart_load_done_pulses: got %0d want 1", ldc); else passed++;
        ld_vals = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        for (int k = 0; k < 8; k++) begin
            total++; if (hi[k] !== int'(ld_vals[k]))
                $display("FAIL restart_ch%0d: got %0d want %0d", k, hi[k], ld_vals[k]); else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_continuous();
        mode = 1'b1; align = 1'b0;
        set_all(8'h40);
        load_vals();
        @(negedge clk);
        total++; if (hsync !== 1'b1) $display("FAIL cont_hsync0: got %b want 1", hsync); else passed++;
        set_all(8'h08);
        measure(50, 70);
        total++; if (hi[0] !== 64 || hi[7] !== 64) $display("FAIL cont_period1: got %0d/%0d want 64", hi[0], hi[7]); else passed++;
        total++; if (hs_c !== 255) $display("FAIL cont_hsync1: got cycle %0d want 255", hs_c); else passed++;
        total++; if (dr_any !== 1'b0) $display("FAIL cont_start_while_full: data_ready got %b want 0", dr_any); else passed++;
        mode = 1'b0;
        measure(0, 0);
        total++; if (hi[0] !== 8 || hi[5] !== 8) $display("FAIL cont_period2: got %0d/%0d want 8", hi[0], hi[5]); else passed++;
        total++; if (hs_c !== 255 || done_c !== -1) $display("FAIL cont_hsync2: got hsync %0d done %0d want 255 -1", hs_c, done_c); else passed++;
        measure(0, 0);
        total++; if (hi[3] !== 8) $display("FAIL cont_period3: got %0d want 8", hi[3]); else passed++;
        total++; if (hs_c !== -1 || done_c !== 255) $display("FAIL cont_end: got hsync %0d done %0d want -1 255", hs_c, done_c); else passed++;
        @(negedge clk);
    endtask

    task automatic test_stop();
        int dn = 0, hs = 0;
        mode = 1'b1; align = 1'b0;
        set_all(8'd50);
        load_vals();
        @(negedge clk);
        total++; if (hsync !== 1'b1) $display("FAIL stop_hsync: got %b want 1", hsync); else passed++;
        repeat (10) @(negedge clk);
        total++; if (out !== 8'hFF) $display("FAIL stop_before: out got %h want ff", out); else passed++;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++; if ({out, done, busy} !== 10'b00000000_1_0)
            $display("FAIL stop_after: out/done/busy got %b want 0000000010", {out, done, busy}); else passed++;
        repeat (300) begin
            @(negedge clk);
            dn += int'(done); hs += int'(hsync);
        end
        total++; if (dn !== 0 || hs !== 0) $display("FAIL stop_quiet: done %0d hsync %0d want 0 0", dn, hs); else passed++;
        load_vals();
        @(negedge clk);
        repeat (254) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++; if ({done, hsync} !== 2'b10) $display("FAIL stop_at_end: done/hsync got %b want 10", {done, hsync}); else passed++;
        hs = 0;
        repeat (300) begin
            @(negedge clk);
            hs += int'(hsync);
        end
        total++; if (hs !== 0) $display("FAIL stop_at_end_quiet: hsync %0d want 0", hs); else passed++;
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        mode = 1'b1; align = 1'b0;
        set_all(8'h80);
        load_vals();
        @(negedge clk);
        repeat (20) @(negedge clk);
        start = 1'b1; data_valid = 1'b1; data = 8'h10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++; if ({data_ready, busy} !== 2'b11) $display("FAIL rstmid_pre: ready/busy got %b want 11", {data_ready, busy}); else passed++;
        rst = 1'b1; data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({out, busy, data_ready, hsync, done} !== 12'b0)
            $display("FAIL rstmid_clear: got %b want 0", {out, busy, data_ready, hsync, done}); else passed++;
        repeat (300) begin
            @(negedge clk);
            hs += int'(hsync);
        end
        total++; if (hs !== 0 || data_ready !== 1'b0) $display("FAIL rstmid_quiet: hsync %0d ready %b want 0 0", hs, data_ready); else passed++;
        mode = 1'b0;
        set_all(8'h05);
        load_vals();
        @(negedge clk);
        total++; if ({hsync, load_done} !== 2'b11) $display("FAIL rstmid_reload: got %b want 11", {hsync, load_done}); else passed++;
        measure(0, 0);
        total++; if (hi[0] !== 5 || hi[7] !== 5 || done_c !== 255)
            $display("FAIL rstmid_frame: got %0d %0d done %0d want 5 5 255", hi[0], hi[7], done_c); else passed++;
    endtask

    initial begin
        test_reset();
        test_oneshot_left();
        test_right();
        test_restart();
        test_continuous();
        test_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
